// File: rtl/de_write_combiner.sv
// de_write_combiner
// Merges byte-masked writes from the draw engine into whole-word writes,
// queues completed words in a small FIFO towards the framebuffer port, and
// forwards reads only after every pending write has left the block so that
// read-after-write ordering holds at the memory.
module de_write_combiner #(
    parameter int DEPTH      = 4,   // completed-word FIFO entries, power of two
    parameter int IDLE_FLUSH = 8    // idle cycles before the combine register is pushed
) (
    input  logic        clk,
    input  logic        rst_n,

    // draw engine side
    input  logic        de_req,
    output logic        de_ack,
    input  logic [17:0] de_addr,
    input  logic [3:0]  de_nbyte,
    input  logic        de_rnw,
    input  logic [31:0] de_w_data,
    output logic [31:0] de_r_data,

    input  logic        flush,
    output logic        idle,

    // framebuffer memory side
    output logic        mem_req,
    input  logic        mem_ack,
    output logic [17:0] mem_addr,
    output logic [3:0]  mem_nbyte,
    output logic        mem_rnw,
    output logic [31:0] mem_w_data,
    input  logic [31:0] mem_r_data
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] FIFO_FULL_CNT = CNT_W'(DEPTH);
    localparam logic [7:0]       IDLE_LIMIT    = 8'(IDLE_FLUSH);
    localparam logic [7:0]       IDLE_LAST     = 8'(IDLE_FLUSH - 1);
    localparam logic [3:0]       NBYTE_NONE    = 4'b1111;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_RDRAIN = 2'd1,
        ST_RREQ   = 2'd2,
        ST_RRESP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t             state_q, state_d;

    // combine register
    logic               cv_q, cv_d;
    logic [17:0]        caddr_q, caddr_d;
    logic [3:0]         cnbyte_q, cnbyte_d;
    logic [31:0]        cdata_q, cdata_d;

    // completed-word FIFO control
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    // idle counter and a flush request that is still waiting for FIFO space
    logic [7:0]         idle_cnt_q, idle_cnt_d;
    logic               flush_pend_q, flush_pend_d;

    // captured read request and read response
    logic [17:0]        raddr_q, raddr_d;
    logic [3:0]         rnbyte_q, rnbyte_d;
    logic [31:0]        rdata_q, rdata_d;

    // FIFO storage, no reset needed: only entries below count_q are ever read
    logic [17:0]        fifo_addr  [DEPTH];
    logic [3:0]         fifo_nbyte [DEPTH];
    logic [31:0]        fifo_data  [DEPTH];

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic               fifo_full;
    logic               fifo_empty;
    logic               hit;
    logic               wr_acc;
    logic               wr_live;
    logic               req_acc;
    logic               head_req;
    logic               pop;
    logic               rd_xfer;
    logic               idle_fire;
    logic               flush_req;
    logic               drain;
    logic               drain_push;
    logic               miss_push;
    logic               push;
    logic [31:0]        merge_data;

    assign fifo_full  = (count_q == FIFO_FULL_CNT);
    assign fifo_empty = (count_q == '0);
    assign hit        = cv_q && (de_addr == caddr_q);

    // Write acceptance looks only at registered state and the request, never
    // at mem_ack, so a full FIFO frees up for new misses one cycle after a pop.
    assign wr_acc  = de_req && !de_rnw && (state_q == ST_RUN) &&
                     (!cv_q || hit || !fifo_full);
    // an all-masked write is acknowledged but carries nothing
    assign wr_live = wr_acc && (de_nbyte != NBYTE_NONE);
    assign req_acc = wr_acc || (state_q == ST_RRESP);

    // FIFO head is offered downstream whenever no read owns the port
    assign head_req = ((state_q == ST_RUN) || (state_q == ST_RDRAIN)) && !fifo_empty;
    assign pop      = head_req && mem_ack;
    assign rd_xfer  = (state_q == ST_RREQ) && mem_ack;

    // fires on the edge that completes the IDLE_FLUSH-th quiet cycle, and keeps
    // firing while the counter sits at its limit (e.g. FIFO was full)
    assign idle_fire = !req_acc && (idle_cnt_q >= IDLE_LAST);
    assign flush_req = flush || flush_pend_q;

    // Retire the combine register without a new write: explicit flush, idle
    // timeout, or draining ahead of a read. An accepted write takes priority
    // because it either merges into or displaces the register itself.
    assign drain      = cv_q && !fifo_full && !wr_acc &&
                        (flush_req || idle_fire || (state_q == ST_RDRAIN));
    assign drain_push = drain && (cnbyte_q != NBYTE_NONE);
    assign miss_push  = wr_live && cv_q && !hit && (cnbyte_q != NBYTE_NONE);
    assign push       = drain_push || miss_push;

    // byte-lane merge of a hit into the combine register
    for (genvar gi = 0; gi < 4; gi++) begin : g_merge
        assign merge_data[8*gi +: 8] = de_nbyte[gi] ? cdata_q[8*gi +: 8]
                                                    : de_w_data[8*gi +: 8];
    end

    // ------------------------------------------------------------------
    // Read-ordering FSM
    // ------------------------------------------------------------------

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // next state: a read waits until nothing is left in front of it
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (de_req && de_rnw) begin
                    state_d = ST_RDRAIN;
                end
            end
            ST_RDRAIN: begin
                if (!cv_q && fifo_empty && !pop) begin
                    state_d = ST_RREQ;
                end
            end
            ST_RREQ: begin
                if (mem_ack) begin
                    state_d = ST_RRESP;
                end
            end
            ST_RRESP: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // outputs: downstream port is either the FIFO head or the pending read
    always_comb begin
        de_ack     = wr_acc || (state_q == ST_RRESP);
        de_r_data  = rdata_q;
        idle       = (state_q == ST_RUN) && !cv_q && fifo_empty;
        mem_req    = 1'b0;
        mem_rnw    = 1'b0;
        mem_addr   = '0;
        mem_nbyte  = NBYTE_NONE;
        mem_w_data = '0;
        if (state_q == ST_RREQ) begin
            mem_req   = 1'b1;
            mem_rnw   = 1'b1;
            mem_addr  = raddr_q;
            mem_nbyte = rnbyte_q;
        end else if (head_req) begin
            mem_req    = 1'b1;
            mem_addr   = fifo_addr[rd_ptr_q];
            mem_nbyte  = fifo_nbyte[rd_ptr_q];
            mem_w_data = fifo_data[rd_ptr_q];
        end
    end

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------

    // combine register: merge on hit, reload on miss, clear when retired
    always_comb begin
        cv_d     = cv_q;
        caddr_d  = caddr_q;
        cnbyte_d = cnbyte_q;
        cdata_d  = cdata_q;
        if (wr_live) begin
            if (hit) begin
                cnbyte_d = cnbyte_q & de_nbyte;
                cdata_d  = merge_data;
            end else begin
                cv_d     = 1'b1;
                caddr_d  = de_addr;
                cnbyte_d = de_nbyte;
                cdata_d  = de_w_data;
            end
        end else if (drain) begin
            cv_d = 1'b0;
        end
    end

    // FIFO pointers and occupancy; push and pop may coincide
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // idle counter saturates at its limit; a flush with nothing to push or
    // that already went out is forgotten
    always_comb begin
        if (req_acc) begin
            idle_cnt_d = '0;
        end else if (idle_cnt_q != IDLE_LIMIT) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
        end else begin
            idle_cnt_d = idle_cnt_q;
        end
        flush_pend_d = flush_req && cv_q && !drain && !miss_push;
    end

    // read request is latched when it arrives; response captured on transfer
    always_comb begin
        raddr_d  = raddr_q;
        rnbyte_d = rnbyte_q;
        rdata_d  = rdata_q;
        if ((state_q == ST_RUN) && de_req && de_rnw) begin
            raddr_d  = de_addr;
            rnbyte_d = de_nbyte;
        end
        if (rd_xfer) begin
            rdata_d = mem_r_data;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------

    // control and datapath flops; reset discards anything pending
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cv_q         <= 1'b0;
            caddr_q      <= '0;
            cnbyte_q     <= NBYTE_NONE;
            cdata_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            idle_cnt_q   <= '0;
            flush_pend_q <= 1'b0;
            raddr_q      <= '0;
            rnbyte_q     <= NBYTE_NONE;
            rdata_q      <= '0;
        end else begin
            cv_q         <= cv_d;
            caddr_q      <= caddr_d;
            cnbyte_q     <= cnbyte_d;
            cdata_q      <= cdata_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            idle_cnt_q   <= idle_cnt_d;
            flush_pend_q <= flush_pend_d;
            raddr_q      <= raddr_d;
            rnbyte_q     <= rnbyte_d;
            rdata_q      <= rdata_d;
        end
    end

    // FIFO storage write; the combine register is always what gets pushed
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr_q]  <= caddr_q;
            fifo_nbyte[wr_ptr_q] <= cnbyte_q;
            fifo_data[wr_ptr_q]  <= cdata_q;
        end
    end

endmodule

// File: tb/tb_de_write_combiner.sv
// Directed bench for de_write_combiner: byte merging, FIFO back-pressure,
// read ordering and latency, idle flush timing, masked writes, async reset.
`timescale 1ns/1ps
module tb_de_write_combiner;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        de_req;
    logic        de_ack;
    logic [17:0] de_addr;
    logic [3:0]  de_nbyte;
    logic        de_rnw;
    logic [31:0] de_w_data;
    logic [31:0] de_r_data;
    logic        flush;
    logic        idle;
    logic        mem_req;
    logic        mem_ack;
    logic [17:0] mem_addr;
    logic [3:0]  mem_nbyte;
    logic        mem_rnw;
    logic [31:0] mem_w_data;
    logic [31:0] mem_r_data;

    always #5 clk = ~clk;

    de_write_combiner #(.DEPTH(4), .IDLE_FLUSH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .de_req     (de_req),
        .de_ack     (de_ack),
        .de_addr    (de_addr),
        .de_nbyte   (de_nbyte),
        .de_rnw     (de_rnw),
        .de_w_data  (de_w_data),
        .de_r_data  (de_r_data),
        .flush      (flush),
        .idle       (idle),
        .mem_req    (mem_req),
        .mem_ack    (mem_ack),
        .mem_addr   (mem_addr),
        .mem_nbyte  (mem_nbyte),
        .mem_rnw    (mem_rnw),
        .mem_w_data (mem_w_data),
        .mem_r_data (mem_r_data)
    );

    // memory model (word i powers up as 0xA0B0C000 | i) and transfer log
    logic [31:0] mem_model [64];
    logic [17:0] log_addr  [64];
    logic [3:0]  log_nbyte [64];
    logic [31:0] log_data  [64];
    logic        log_rnw   [64];
    int          log_cnt = 0;

    assign mem_r_data = mem_model[mem_addr[5:0]];

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) begin
                mem_model[i] <= 32'hA0B0C000 | 32'(i);
            end
        end else if (mem_req && mem_ack) begin
            if (log_cnt < 64) begin
                log_addr[log_cnt]  <= mem_addr;
                log_nbyte[log_cnt] <= mem_nbyte;
                log_data[log_cnt]  <= mem_w_data;
                log_rnw[log_cnt]   <= mem_rnw;
            end
            log_cnt <= log_cnt + 1;
            if (!mem_rnw) begin
                for (int b = 0; b < 4; b++) begin
                    if (!mem_nbyte[b]) begin
                        mem_model[mem_addr[5:0]][8*b +: 8] <= mem_w_data[8*b +: 8];
                    end
                end
            end
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // wait (bounded) for de_ack on an already-driven request, then release it
    task automatic wait_ack(input string tag);
        logic got;
        got = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (de_ack) begin
                got = 1'b1;
                break;
            end
        end
        check(tag, got, 1'b1);
        @(posedge clk);
        #1;
        de_req = 1'b0;
    endtask

    task automatic de_write(input logic [17:0] a, input logic [3:0] nb, input logic [31:0] d);
        de_req    = 1'b1;
        de_rnw    = 1'b0;
        de_addr   = a;
        de_nbyte  = nb;
        de_w_data = d;
        wait_ack("wr_ack");
    endtask

    task automatic de_read(input logic [17:0] a, output logic [31:0] rd, output int lat);
        de_req   = 1'b1;
        de_rnw   = 1'b1;
        de_addr  = a;
        de_nbyte = 4'b0000;
        lat      = -1;
        rd       = '0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (de_ack) begin
                lat = n;
                rd  = de_r_data;
                break;
            end
        end
        check("rd_ack_seen", 64'(lat >= 0), 64'd1);
        @(posedge clk);
        #1;
        de_req = 1'b0;
        de_rnw = 1'b0;
        @(negedge clk);
        check("rd_ack_single", de_ack, 1'b0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          base;
        int          lat;
        int          cnt;
        logic [31:0] rd;

        rst_n     = 1'b0;
        de_req    = 1'b0;
        de_addr   = '0;
        de_nbyte  = 4'b1111;
        de_rnw    = 1'b0;
        de_w_data = '0;
        flush     = 1'b0;
        mem_ack   = 1'b0;

        // reset values
        #12;
        check("rst_de_ack", de_ack, 1'b0);
        check("rst_de_r_data", de_r_data, 32'h0);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_addr", mem_addr, 18'h0);
        check("rst_mem_nbyte", mem_nbyte, 4'b1111);
        check("rst_mem_rnw", mem_rnw, 1'b0);
        check("rst_mem_w_data", mem_w_data, 32'h0);
        check("rst_idle", idle, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(2);

        // four byte writes to one word, then flush -> one merged word
        mem_ack = 1'b1;
        base = log_cnt;
        de_write(18'h00010, 4'b1110, 32'h000000AA);
        de_write(18'h00010, 4'b1101, 32'h0000BB00);
        de_write(18'h00010, 4'b1011, 32'h00CC0000);
        de_write(18'h00010, 4'b0111, 32'hDD000000);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        tick(6);
        check("merge_count", log_cnt - base, 1);
        check("merge_addr", log_addr[base], 18'h00010);
        check("merge_nbyte", log_nbyte[base], 4'b0000);
        check("merge_data", log_data[base], 32'hDDCCBBAA);
        check("merge_rnw", log_rnw[base], 1'b0);
        check("merge_idle", idle, 1'b1);

        // back-pressure: words 0..4 fill combine + FIFO, word 5 must stall
        mem_ack = 1'b0;
        base = log_cnt;
        for (int i = 0; i < 5; i++) begin
            de_write(18'(i), 4'b1110, 32'h10 + 32'(i));
        end
        check("full_mem_req", mem_req, 1'b1);
        check("full_head_addr", mem_addr, 18'h0);
        de_req    = 1'b1;
        de_rnw    = 1'b0;
        de_addr   = 18'h5;
        de_nbyte  = 4'b1110;
        de_w_data = 32'h15;
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (de_ack) cnt++;
        end
        check("full_block_acks", cnt, 0);
        mem_ack = 1'b1;
        wait_ack("full_release_ack");
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (idle && (log_cnt - base == 6)) break;
        end
        check("full_count", log_cnt - base, 6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("full_addr%0d", i), log_addr[base + i], 18'(i));
            check($sformatf("full_data%0d", i), log_data[base + i][7:0], 8'h10 + 8'(i));
        end
        @(posedge clk);
        #1;

        // read after write: write must reach memory first
        base = log_cnt;
        de_write(18'h3, 4'b1110, 32'h00000055);
        de_read(18'h3, rd, lat);
        check("raw_rdata", rd, 32'hA0B0C055);
        check("raw_count", log_cnt - base, 2);
        check("raw_first_rnw", log_rnw[base], 1'b0);
        check("raw_first_addr", log_addr[base], 18'h3);
        check("raw_second_rnw", log_rnw[base + 1], 1'b1);
        check("raw_second_addr", log_addr[base + 1], 18'h3);

        // read from an idle block: 3 cycles request to ack
        de_read(18'h7, rd, lat);
        check("rd_latency", lat, 3);
        check("rd_idle_data", rd, 32'hA0B0C007);

        // idle flush: push on the edge ending the 8th quiet cycle
        base = log_cnt;
        de_write(18'h00020, 4'b1011, 32'h00330000);
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            if (k == 7) check("idlef_req_early", mem_req, 1'b0);
            if (k == 8) begin
                check("idlef_req", mem_req, 1'b1);
                check("idlef_addr", mem_addr, 18'h00020);
                check("idlef_nbyte", mem_nbyte, 4'b1011);
                check("idlef_wdata", mem_w_data, 32'h00330000);
            end
        end
        tick(1);
        check("idlef_count", log_cnt - base, 1);
        check("idlef_idle", idle, 1'b1);

        // fully masked write: acknowledged, nothing downstream
        base = log_cnt;
        de_write(18'h00030, 4'b1111, 32'hDEADBEEF);
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (!idle || mem_req) cnt++;
        end
        check("mask_busy_cycles", cnt, 0);
        check("mask_count", log_cnt - base, 0);
        @(posedge clk);
        #1;

        // asynchronous reset with queued words
        mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            de_write(18'h40 + 18'(i), 4'b1110, 32'h60 + 32'(i));
        end
        check("prst_mem_req", mem_req, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_mem_req", mem_req, 1'b0);
        check("arst_mem_addr", mem_addr, 18'h0);
        check("arst_mem_nbyte", mem_nbyte, 4'b1111);
        check("arst_mem_w_data", mem_w_data, 32'h0);
        check("arst_de_r_data", de_r_data, 32'h0);
        check("arst_idle", idle, 1'b1);
        mem_ack = 1'b1;
        tick(2);
        rst_n = 1'b1;
        base = log_cnt;
        tick(20);
        check("arst_no_xfer", log_cnt - base, 0);
        check("arst_idle_after", idle, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
